// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared DDR read-port types and arbiter configuration
package config_pkg;

    localparam int NumDdrRequesters = 4;
    localparam int DdrAddrWidth     = 32;
    localparam int DdrDataWidth     = 64;

    typedef logic [$clog2(NumDdrRequesters)-1:0] ddr_req_id_t;
    typedef logic [DdrAddrWidth-1:0]             ddr_address_t;
    typedef logic [DdrDataWidth-1:0]             ddr_data_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick: first pending bit at or after rr_ptr_i
module rr_picker #(
    parameter int  NumReq = 4,
    localparam int IdW    = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] pending_i,
    input  logic [IdW-1:0]    rr_ptr_i,
    output logic              grant_valid_o,
    output logic [IdW-1:0]    grant_id_o
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_id_o    = '0;
        idx           = 0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_i) + i;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            if (pending_i[idx[IdW-1:0]]) begin
                grant_valid_o = 1'b1;
                grant_id_o    = idx[IdW-1:0];
            end
        end
    end

endmodule

// File: rtl/ddr_read_arbiter.sv
// rtl/ddr_read_arbiter.sv - round-robin sharing of one DDR read port, one read in flight
// Optional grant counters with DDR_ARB_STATS_EN.
module ddr_read_arbiter
    import config_pkg::*;
#(
    parameter int NumReq     = NumDdrRequesters,
    parameter int StatsWidth = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumReq-1:0]        req_en_i,
    input  ddr_address_t [NumReq-1:0] req_addr_i,
    output logic [NumReq-1:0]        rsp_valid_o,
    output ddr_data_t                rsp_data_o,
    output ddr_address_t             ddr_address_o,
    output logic                     ddr_r_en_o,
    input  ddr_data_t                ddr_r_data_i,
    input  logic                     ddr_r_valid_i,
    output logic                     busy_o
`ifdef DDR_ARB_STATS_EN
    ,
    output logic [NumReq-1:0][StatsWidth-1:0] grant_count_o
`endif
);

    localparam int IdW = $clog2(NumReq);

    if (NumReq < 2 || StatsWidth < 1) begin : g_param_check
        $error("ddr_read_arbiter: NumReq must be >= 2 and StatsWidth >= 1");
    end

    arb_state_e                state_q, state_d;
    logic [NumReq-1:0]         pending_q, pending_d;
    ddr_address_t [NumReq-1:0] addr_q, addr_d;
    logic [IdW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]            owner_q, owner_d;
    logic                      ddr_r_en_q, ddr_r_en_d;
    ddr_address_t              ddr_address_q, ddr_address_d;
    logic [NumReq-1:0]         rsp_valid_q, rsp_valid_d;
    ddr_data_t                 rsp_data_q, rsp_data_d;

    logic                      grant_valid;
    logic [IdW-1:0]            grant_id;
    logic                      issue;
    logic                      complete;
    logic [NumReq-1:0]         done_mask;

    rr_picker #(
        .NumReq(NumReq)
    ) u_rr_picker (
        .pending_i    (pending_q),
        .rr_ptr_i     (rr_ptr_q),
        .grant_valid_o(grant_valid),
        .grant_id_o   (grant_id)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: if (grant_valid)   state_d = ARB_WAIT;
            ARB_WAIT: if (ddr_r_valid_i) state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        issue         = (state_q == ARB_IDLE) && grant_valid;
        complete      = (state_q == ARB_WAIT) && ddr_r_valid_i;
        done_mask     = '0;
        ddr_r_en_d    = issue;
        ddr_address_d = issue ? addr_q[grant_id] : ddr_address_q;
        owner_d       = issue ? grant_id : owner_q;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
        rr_ptr_d      = rr_ptr_q;
        addr_d        = addr_q;
        if (complete) begin
            done_mask[owner_q]   = 1'b1;
            rsp_valid_d[owner_q] = 1'b1;
            rsp_data_d           = ddr_r_data_i;
            rr_ptr_d             = (owner_q == IdW'(NumReq - 1)) ? '0 : owner_q + 1'b1;
        end
        // Completion clears first so the owner may re-request on its own completion edge.
        pending_d = pending_q & ~done_mask;
        for (int n = 0; n < NumReq; n++) begin
            if (req_en_i[n] && !pending_d[n]) begin
                pending_d[n] = 1'b1;
                addr_d[n]    = req_addr_i[n];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q     <= '0;
            addr_q        <= '0;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            ddr_r_en_q    <= 1'b0;
            ddr_address_q <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
        end else begin
            pending_q     <= pending_d;
            addr_q        <= addr_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            ddr_r_en_q    <= ddr_r_en_d;
            ddr_address_q <= ddr_address_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

    assign ddr_r_en_o    = ddr_r_en_q;
    assign ddr_address_o = ddr_address_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign busy_o        = (state_q == ARB_WAIT) || (|pending_q);

`ifdef DDR_ARB_STATS_EN
    logic [NumReq-1:0][StatsWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (issue && (cnt_q[grant_id] != '1)) begin
            cnt_d[grant_id] = cnt_q[grant_id] + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_count_o = cnt_q;
`endif

    // Protocol violations are ignored by the logic above; these only flag them.
    a_req_while_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_en_i & pending_q & ~done_mask) == '0)
        else $warning("protocol violation: req_en on a requester that is already pending");

    a_valid_in_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !((state_q == ARB_IDLE) && ddr_r_valid_i))
        else $warning("protocol violation: ddr_r_valid with no read in flight");

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// tb/tb_ddr_read_arbiter.sv - scoreboard bench for ddr_read_arbiter (optional DDR_ARB_STATS_EN)
module tb_ddr_read_arbiter;
    import config_pkg::*;

    localparam int NR = 4;
`ifdef DDR_ARB_STATS_EN
    localparam int SW = 2;
`else
    localparam int SW = 32;
`endif

    logic                  clk;
    logic                  rst_ni;
    logic [NR-1:0]         req_en_i;
    ddr_address_t [NR-1:0] req_addr_i;
    logic [NR-1:0]         rsp_valid_o;
    ddr_data_t             rsp_data_o;
    ddr_address_t          ddr_address_o;
    logic                  ddr_r_en_o;
    ddr_data_t             ddr_r_data_i;
    logic                  ddr_r_valid_i;
    logic                  busy_o;
`ifdef DDR_ARB_STATS_EN
    logic [NR-1:0][SW-1:0] grant_count_o;
`endif

    ddr_read_arbiter #(.NumReq(NR), .StatsWidth(SW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_en_i     (req_en_i),
        .req_addr_i   (req_addr_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .ddr_address_o(ddr_address_o),
        .ddr_r_en_o   (ddr_r_en_o),
        .ddr_r_data_i (ddr_r_data_i),
        .ddr_r_valid_i(ddr_r_valid_i),
        .busy_o       (busy_o)
`ifdef DDR_ARB_STATS_EN
        ,
        .grant_count_o(grant_count_o)
`endif
    );

    logic [NR-1:0] pk_pend;
    logic [1:0]    pk_ptr;
    logic          pk_valid;
    logic [1:0]    pk_id;

    rr_picker #(.NumReq(NR)) u_pick (
        .pending_i    (pk_pend),
        .rr_ptr_i     (pk_ptr),
        .grant_valid_o(pk_valid),
        .grant_id_o   (pk_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct { ddr_address_t addr; int edge_n; } grant_t;
    typedef struct { int owner; ddr_data_t data; int edge_n; } rsp_t;

    grant_t       gq[$];
    rsp_t         rq[$];
    ddr_address_t obs[$];
    int           checks = 0;
    int           failures = 0;
    bit           mon_en = 0;

    // Transaction-level reference: pending set, rr pointer, one read in flight.
    bit           m_pend[NR];
    ddr_address_t m_addr[NR];
    longint       m_cnt[NR];
    int           m_ptr, m_owner, m_due;
    bit           m_inflight;
    ddr_data_t    m_last;
    longint       sat = (longint'(1) << SW) - 1;

    ddr_address_t  a_in[NR];
    logic [NR-1:0] force_req;
    bit            rereq0, fixed_en;
    ddr_data_t     fixed_data;
    int            lat_min, lat_max;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit any_pend();
        bit r = 0;
        for (int n = 0; n < NR; n++) r |= m_pend[n];
        return r;
    endfunction

    task automatic apply(input bit rst, input logic [NR-1:0] req, input bit vld, input ddr_data_t vdata);
        int e;
        e = edge_cnt + 1;
        rst_ni        = !rst;
        req_en_i      = req;
        ddr_r_valid_i = vld;
        ddr_r_data_i  = vdata;
        for (int n = 0; n < NR; n++) req_addr_i[n] = a_in[n];
        if (rst) begin
            for (int n = 0; n < NR; n++) begin
                m_pend[n] = 0;
                m_cnt[n]  = 0;
            end
            m_ptr = 0; m_inflight = 0; m_last = '0;
            return;
        end
        if (m_inflight) begin
            if (vld) begin
                rq.push_back('{m_owner, vdata, e});
                m_pend[m_owner] = 0;
                m_ptr      = (m_owner + 1) % NR;
                m_inflight = 0;
                m_last     = vdata;
            end
        end else begin
            for (int k = 0; k < NR; k++) begin
                int c;
                c = (m_ptr + k) % NR;
                if (!m_inflight && m_pend[c]) begin
                    gq.push_back('{m_addr[c], e});
                    m_inflight = 1;
                    m_owner    = c;
                    m_due      = e + $urandom_range(lat_max, lat_min);
                    if (m_cnt[c] < sat) m_cnt[c]++;
                end
            end
        end
        for (int n = 0; n < NR; n++) begin
            if (req[n] && !m_pend[n]) begin
                m_pend[n] = 1;
                m_addr[n] = a_in[n];
            end
        end
    endtask

    task automatic run(input int ncyc, input int pct);
        for (int i = 0; i < ncyc; i++) begin
            logic [NR-1:0] req;
            bit vld, free;
            int e;
            @(negedge clk);
            e   = edge_cnt + 1;
            vld = m_inflight && (e >= m_due);
            req = force_req;
            force_req = '0;
            for (int n = 0; n < NR; n++) begin
                free = !m_pend[n] || (vld && n == m_owner);
                if (!req[n] && free &&
                    ((rereq0 && n == 0 && vld && m_owner == 0) || $urandom_range(99) < pct)) begin
                    req[n]  = 1'b1;
                    a_in[n] = $urandom;
                end
            end
            apply(0, req, vld, fixed_en ? fixed_data : {$urandom, $urandom});
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((m_inflight || any_pend()) && guard < 500) begin
            run(1, 0);
            guard++;
        end
        chk("drain_timeout", guard < 500, 1);
        run(2, 0);
    endtask

    task automatic monitor_cycle();
        int e;
        e = edge_cnt;
        while (gq.size() > 0 && gq[0].edge_n < e) begin
            chk("missing_grant", 0, 1);
            void'(gq.pop_front());
        end
        while (rq.size() > 0 && rq[0].edge_n < e) begin
            chk("missing_rsp", 0, 1);
            void'(rq.pop_front());
        end
        if (ddr_r_en_o === 1'b1) begin
            obs.push_back(ddr_address_o);
            if (gq.size() == 0) chk("unexpected_grant", 1, 0);
            else begin
                grant_t g;
                g = gq.pop_front();
                chk("grant_addr", ddr_address_o, g.addr);
                chk("grant_edge", e, g.edge_n);
            end
        end
        if (rsp_valid_o !== '0) begin
            if (rq.size() == 0) chk("unexpected_rsp", rsp_valid_o, 0);
            else begin
                rsp_t r;
                r = rq.pop_front();
                chk("rsp_owner", rsp_valid_o, 64'(1) << r.owner);
                chk("rsp_data", rsp_data_o, r.data);
                chk("rsp_edge", e, r.edge_n);
            end
        end else begin
            chk("rsp_data_hold", rsp_data_o, m_last);
        end
        chk("busy", busy_o, m_inflight || any_pend());
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) monitor_cycle();
        end
    end

    initial begin
        bit ev;
        int eid;
        for (int p = 0; p < NR; p++) begin
            for (int v = 0; v < 16; v++) begin
                pk_ptr  = p[1:0];
                pk_pend = v[3:0];
                #1;
                ev = 0; eid = 0;
                for (int k = 0; k < NR; k++) begin
                    int c;
                    c = (p + k) % NR;
                    if (!ev && v[c]) begin ev = 1; eid = c; end
                end
                chk("pick_valid", pk_valid, ev);
                if (ev) chk("pick_id", pk_id, eid);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, idx3;
        rst_ni = 0; req_en_i = '0; req_addr_i = '0; ddr_r_valid_i = 0; ddr_r_data_i = '0;
        for (int n = 0; n < NR; n++) a_in[n] = '0;
        force_req = '0; rereq0 = 0; fixed_en = 0; fixed_data = '0;
        lat_min = 1; lat_max = 4;

        @(negedge clk); apply(1, '0, 0, '0);
        @(negedge clk); apply(1, '0, 0, '0);
        mon_en = 1;
        @(posedge clk); #3;
        chk("reset_addr", ddr_address_o, 0);
        chk("reset_ren", ddr_r_en_o, 0);
        chk("reset_rsp_valid", rsp_valid_o, 0);
        chk("reset_rsp_data", rsp_data_o, 0);

        // All four at once from rr_ptr=0
        for (int n = 0; n < NR; n++) a_in[n] = 32'h10 + n;
        base = obs.size();
        force_req = '1;
        run(1, 0); drain();
        chk("t2_count", obs.size() - base, 4);
        for (int k = 0; k < 4 && base + k < obs.size(); k++) chk("t2_order", obs[base + k], 32'h10 + k);

        // Single request, DDR answers 3 cycles after the strobe
        base = obs.size();
        a_in[2] = 32'h40; lat_min = 3; lat_max = 3; fixed_en = 1; fixed_data = 64'hAB;
        force_req = 4'b0100;
        run(1, 0); drain();
        fixed_en = 0;
        chk("t1_addr", (obs.size() > base) ? obs[base] : 32'hFFFF_FFFF, 32'h40);

        // Fairness: req0 re-requests on each completion, req3 asks once
        lat_min = 1; lat_max = 3; rereq0 = 1;
        base = obs.size();
        a_in[0] = 32'h1000; force_req = 4'b0001; run(3, 0);
        a_in[3] = 32'h3000; force_req = 4'b1000; run(14, 0);
        rereq0 = 0; drain();
        idx3 = -1;
        for (int k = base; k < obs.size(); k++) if (idx3 < 0 && obs[k] == 32'h3000) idx3 = k;
        chk("t3_req3_granted", idx3 >= 0, 1);
        chk("t3_wait_bound", (idx3 - base) <= NR - 1, 1);

        // Reset mid-WAIT then a stray valid
        lat_min = 40; lat_max = 40;
        a_in[1] = 32'h77; force_req = 4'b0010; run(4, 0);
        @(negedge clk); apply(1, '0, 0, '0);
        @(negedge clk); apply(0, '0, 1, 64'hBEEF);
        run(3, 0);
        lat_min = 1; lat_max = 4;
        for (int n = 0; n < NR; n++) a_in[n] = 32'h20 + n;
        base = obs.size();
        force_req = '1; run(1, 0); drain();
        chk("t4_first_after_reset", (obs.size() > base) ? obs[base] : 32'hFFFF_FFFF, 32'h20);

        // Violations: re-request while pending, valid while idle
        lat_min = 4; lat_max = 4;
        base = obs.size();
        a_in[0] = 32'h50; a_in[1] = 32'h51; force_req = 4'b0011; run(1, 0);
        a_in[1] = 32'hBAD; force_req = 4'b0010; run(2, 0);
        drain();
        idx3 = 0;
        for (int k = base; k < obs.size(); k++) if (obs[k] == 32'hBAD) idx3++;
        chk("t5_no_overwrite", idx3, 0);
        @(negedge clk); apply(0, '0, 1, 64'hDEAD);
        run(3, 0);

`ifdef DDR_ARB_STATS_EN
        lat_min = 1; lat_max = 2;
        for (int k = 0; k < 5; k++) begin
            a_in[1] = 32'h60 + k; force_req = 4'b0010; run(1, 0); drain();
        end
        @(posedge clk); #3;
        for (int n = 0; n < NR; n++) chk("stats_count", grant_count_o[n], m_cnt[n]);
`endif

        lat_min = 1; lat_max = 6;
        run(3000, 30);
        drain();
`ifdef DDR_ARB_STATS_EN
        @(posedge clk); #3;
        for (int n = 0; n < NR; n++) chk("stats_final", grant_count_o[n], m_cnt[n]);
`endif
        chk("grant_queue_empty", gq.size(), 0);
        chk("rsp_queue_empty", rq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
